// File: rtl/md_sequencer_pkg.sv
// Shared op codes, FSM states and decode helper for the multiply/divide sequencer.
package md_sequencer_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Ops that occupy the shared multi-cycle unit (everything except mthi/mtlo).
  function automatic logic md_is_arith(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// E/D-stage request signals and HI/LO/busy/stall results between pipeline and md sequencer.
interface md_sequencer_if;
  import md_sequencer_pkg::*;

  logic [3:0]        E_md_op;
  logic              E_md_start;
  logic [WORD_W-1:0] E_rs_val;
  logic [WORD_W-1:0] E_rt_val;
  logic              D_uses_md;
  logic              md_busy;
  logic              md_stall;
  logic [WORD_W-1:0] HI;
  logic [WORD_W-1:0] LO;

  modport master (
    output E_md_op, E_md_start, E_rs_val, E_rt_val, D_uses_md,
    input  md_busy, md_stall, HI, LO
  );

  modport slave (
    input  E_md_op, E_md_start, E_rs_val, E_rt_val, D_uses_md,
    output md_busy, md_stall, HI, LO
  );

endinterface

// File: rtl/md_sequencer_arith.sv
// Combinational multiply/divide datapath: op + operands -> {hi,lo}, plus divide-by-zero flag.
module md_sequencer_arith
  import md_sequencer_pkg::*;
(
  input  logic [3:0]        i_op,
  input  logic [WORD_W-1:0] i_rs,
  input  logic [WORD_W-1:0] i_rt,
  output logic [WORD_W-1:0] o_hi,
  output logic [WORD_W-1:0] o_lo,
  output logic              o_div_zero
);

  logic                     w_rt_zero;
  logic                     w_div_ovf;
  logic signed [2*WORD_W-1:0] w_rs_sx;
  logic signed [2*WORD_W-1:0] w_rt_sx;
  logic signed [2*WORD_W-1:0] w_prod_s;
  logic        [2*WORD_W-1:0] w_prod_u;
  logic signed [WORD_W-1:0] w_rs_s;
  logic signed [WORD_W-1:0] w_dsr_s;
  logic signed [WORD_W-1:0] w_quo_s;
  logic signed [WORD_W-1:0] w_rem_s;
  logic        [WORD_W-1:0] w_dsr_u;
  logic        [WORD_W-1:0] w_quo_u;
  logic        [WORD_W-1:0] w_rem_u;

  assign w_rt_zero = (i_rt == '0);
  assign w_div_ovf = (i_rs == 32'h8000_0000) && (i_rt == 32'hFFFF_FFFF);

  assign w_rs_sx  = {{WORD_W{i_rs[WORD_W-1]}}, i_rs};
  assign w_rt_sx  = {{WORD_W{i_rt[WORD_W-1]}}, i_rt};
  assign w_prod_s = w_rs_sx * w_rt_sx;
  assign w_prod_u = {{WORD_W{1'b0}}, i_rs} * {{WORD_W{1'b0}}, i_rt};

  // Divisor forced to 1 for /0 and MIN/-1 so the divider never sees an undefined case.
  assign w_rs_s  = i_rs;
  assign w_dsr_s = (w_rt_zero || w_div_ovf) ? 32'sd1 : $signed(i_rt);
  assign w_quo_s = w_rs_s / w_dsr_s;
  assign w_rem_s = w_rs_s % w_dsr_s;
  assign w_dsr_u = w_rt_zero ? 32'd1 : i_rt;
  assign w_quo_u = i_rs / w_dsr_u;
  assign w_rem_u = i_rs % w_dsr_u;

  always_comb begin
    o_hi       = '0;
    o_lo       = '0;
    o_div_zero = 1'b0;
    case (i_op)
      MD_MULT:  {o_hi, o_lo} = w_prod_s;
      MD_MULTU: {o_hi, o_lo} = w_prod_u;
      MD_DIV: begin
        o_div_zero = w_rt_zero;
        if (w_div_ovf) begin
          o_lo = 32'h8000_0000;
          o_hi = '0;
        end else begin
          o_lo = w_quo_s;
          o_hi = w_rem_s;
        end
      end
      MD_DIVU: begin
        o_div_zero = w_rt_zero;
        o_lo       = w_quo_u;
        o_hi       = w_rem_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: busy countdown, shadow result, HI/LO registers and D-stage stall.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  md_sequencer_if.slave bus
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  md_state_e         r_state;
  md_state_e         w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [WORD_W-1:0] r_hi;
  logic [WORD_W-1:0] r_lo;
  logic [WORD_W-1:0] r_sh_hi;
  logic [WORD_W-1:0] r_sh_lo;
  logic [WORD_W-1:0] w_ar_hi;
  logic [WORD_W-1:0] w_ar_lo;
  logic              w_div_zero;
  logic              w_idle;
  logic              w_op_arith;
  logic              w_accept;
  logic              w_commit;
  logic              w_mthi;
  logic              w_mtlo;

  md_sequencer_arith u_arith (
    .i_op       (bus.E_md_op),
    .i_rs       (bus.E_rs_val),
    .i_rt       (bus.E_rt_val),
    .o_hi       (w_ar_hi),
    .o_lo       (w_ar_lo),
    .o_div_zero (w_div_zero)
  );

  assign w_idle     = (r_state == ST_IDLE);
  assign w_op_arith = bus.E_md_start && md_is_arith(bus.E_md_op);
  assign w_accept   = w_op_arith && w_idle;
  assign w_mthi     = bus.E_md_start && (bus.E_md_op == MD_MTHI) && w_idle;
  assign w_mtlo     = bus.E_md_start && (bus.E_md_op == MD_MTLO) && w_idle;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = md_is_div(bus.E_md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A divide by zero captures the current HI/LO so the commit leaves them unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sh_hi <= '0;
      r_sh_lo <= '0;
    end else if (w_accept) begin
      r_sh_hi <= w_div_zero ? r_hi : w_ar_hi;
      r_sh_lo <= w_div_zero ? r_lo : w_ar_lo;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      r_hi <= r_sh_hi;
      r_lo <= r_sh_lo;
    end else begin
      if (w_mthi) r_hi <= bus.E_rs_val;
      if (w_mtlo) r_lo <= bus.E_rs_val;
    end
  end

  assign bus.md_busy  = (r_state == ST_RUN);
  assign bus.md_stall = bus.D_uses_md && (bus.md_busy || w_op_arith);
  assign bus.HI       = r_hi;
  assign bus.LO       = r_lo;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer: arithmetic results, busy window, stall, reset.
module tb_md_sequencer;
  import md_sequencer_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  md_sequencer_if bus ();

  md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.E_md_start = 1'b1;
    bus.E_md_op    = op;
    bus.E_rs_val   = rs;
    bus.E_rt_val   = rt;
    step();
    bus.E_md_start = 1'b0;
    bus.E_md_op    = MD_NONE;
    bus.E_rs_val   = '0;
    bus.E_rt_val   = '0;
  endtask

  // Issues one multi-cycle op, then checks busy and stable HI/LO for n cycles and the commit.
  task automatic run_md_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                           input logic [31:0] rt, input int n,
                           input logic [31:0] old_hi, input logic [31:0] old_lo,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(op, rs, rt);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (bus.md_busy !== 1'b1 || bus.HI !== old_hi || bus.LO !== old_lo)
        $display("FAIL %s run cycle %0d: busy=%b HI=%h LO=%h, want busy=1 HI=%h LO=%h",
                 name, i, bus.md_busy, bus.HI, bus.LO, old_hi, old_lo);
      else passed++;
      step();
    end
    checks++;
    if (bus.md_busy !== 1'b0) $display("FAIL %s busy end: got %b want 0", name, bus.md_busy);
    else passed++;
    checks++;
    if (bus.HI !== exp_hi) $display("FAIL %s HI: got %h want %h", name, bus.HI, exp_hi);
    else passed++;
    checks++;
    if (bus.LO !== exp_lo) $display("FAIL %s LO: got %h want %h", name, bus.LO, exp_lo);
    else passed++;
  endtask

  task automatic test_reset();
    bus.E_md_start = 1'b0;
    bus.E_md_op    = MD_NONE;
    bus.E_rs_val   = '0;
    bus.E_rt_val   = '0;
    bus.D_uses_md  = 1'b1;
    #1 reset = 1'b0;
    step();
    step();
    checks++;
    if (bus.HI !== 32'h0 || bus.LO !== 32'h0)
      $display("FAIL reset hilo: got HI=%h LO=%h want 0/0", bus.HI, bus.LO);
    else passed++;
    checks++;
    if (bus.md_busy !== 1'b0 || bus.md_stall !== 1'b0)
      $display("FAIL reset busy/stall: got %b/%b want 0/0", bus.md_busy, bus.md_stall);
    else passed++;
    reset         = 1'b1;
    bus.D_uses_md = 1'b0;
    step();
  endtask

  task automatic test_mult();
    run_md_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd5, MC, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
  endtask

  task automatic test_multu();
    run_md_op("multu", MD_MULTU, 32'hFFFF_FFFD, 32'd5, MC,
              32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'h0000_0004, 32'hFFFF_FFF1);
  endtask

  task automatic test_div();
    run_md_op("div", MD_DIV, 32'd7, 32'hFFFF_FFFE, DC,
              32'h0000_0004, 32'hFFFF_FFF1, 32'h0000_0001, 32'hFFFF_FFFD);
    run_md_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, DC,
              32'h0000_0001, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DC,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0000, 32'h8000_0000);
    run_md_op("divu", MD_DIVU, 32'd100, 32'd7, DC,
              32'h0000_0000, 32'h8000_0000, 32'h0000_0002, 32'h0000_000E);
  endtask

  task automatic test_divu_zero();
    issue(MD_MTHI, 32'h11, 32'h0);
    checks++;
    if (bus.HI !== 32'h11 || bus.md_busy !== 1'b0)
      $display("FAIL mthi: got HI=%h busy=%b want 11/0", bus.HI, bus.md_busy);
    else passed++;
    issue(MD_MTLO, 32'h22, 32'h0);
    checks++;
    if (bus.LO !== 32'h22 || bus.HI !== 32'h11)
      $display("FAIL mtlo: got HI=%h LO=%h want 11/22", bus.HI, bus.LO);
    else passed++;
    run_md_op("divu_zero", MD_DIVU, 32'd9, 32'd0, DC, 32'h11, 32'h22, 32'h11, 32'h22);
    run_md_op("div_zero", MD_DIV, 32'hFFFF_FFF0, 32'd0, DC, 32'h11, 32'h22, 32'h11, 32'h22);
  endtask

  task automatic test_stall();
    bus.D_uses_md = 1'b1;
    #1;
    checks++;
    if (bus.md_stall !== 1'b0) $display("FAIL stall idle: got %b want 0", bus.md_stall);
    else passed++;
    bus.E_md_start = 1'b1;
    bus.E_md_op    = MD_MTHI;
    #1;
    checks++;
    if (bus.md_stall !== 1'b0) $display("FAIL stall mthi: got %b want 0", bus.md_stall);
    else passed++;
    bus.E_md_op  = MD_MULT;
    bus.E_rs_val = 32'd3;
    bus.E_rt_val = 32'd4;
    #1;
    checks++;
    if (bus.md_stall !== 1'b1 || bus.md_busy !== 1'b0)
      $display("FAIL stall accept: got stall=%b busy=%b want 1/0", bus.md_stall, bus.md_busy);
    else passed++;
    step();
    bus.E_md_start = 1'b0;
    bus.E_md_op    = MD_NONE;
    for (int i = 0; i < MC; i++) begin
      checks++;
      if (bus.md_stall !== 1'b1) $display("FAIL stall busy %0d: got %b want 1", i, bus.md_stall);
      else passed++;
      step();
    end
    checks++;
    if (bus.md_stall !== 1'b0 || bus.HI !== 32'h0 || bus.LO !== 32'h0000_000C)
      $display("FAIL stall commit: got stall=%b HI=%h LO=%h want 0/0/c",
               bus.md_stall, bus.HI, bus.LO);
    else passed++;
    bus.D_uses_md = 1'b0;
  endtask

  task automatic test_reset_mid();
    issue(MD_DIV, 32'd100, 32'd3);
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (bus.md_busy !== 1'b1) $display("FAIL rstmid busy before: got %b want 1", bus.md_busy);
    else passed++;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.HI !== 32'h0 || bus.LO !== 32'h0 || bus.md_busy !== 1'b0)
      $display("FAIL rstmid async: got HI=%h LO=%h busy=%b want 0/0/0",
               bus.HI, bus.LO, bus.md_busy);
    else passed++;
    #1 reset = 1'b1;
    step();
    step();
    checks++;
    if (bus.md_busy !== 1'b0 || bus.HI !== 32'h0 || bus.LO !== 32'h0)
      $display("FAIL rstmid after: got busy=%b HI=%h LO=%h want 0/0/0",
               bus.md_busy, bus.HI, bus.LO);
    else passed++;
  endtask

  task automatic test_mtlo();
    issue(MD_MTLO, 32'h0000_ABCD, 32'h0);
    checks++;
    if (bus.LO !== 32'h0000_ABCD || bus.HI !== 32'h0)
      $display("FAIL mtlo after reset: got HI=%h LO=%h want 0/abcd", bus.HI, bus.LO);
    else passed++;
    checks++;
    if (bus.md_busy !== 1'b0) $display("FAIL mtlo busy: got %b want 0", bus.md_busy);
    else passed++;
    step();
    checks++;
    if (bus.md_busy !== 1'b0 || bus.LO !== 32'h0000_ABCD)
      $display("FAIL mtlo hold: got busy=%b LO=%h want 0/abcd", bus.md_busy, bus.LO);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divu_zero();
    test_stall();
    test_reset_mid();
    test_mtlo();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
